// File: rtl/lap_stop_watch.sv
// Stopwatch with centisecond BCD time, pause/resume, clear, and a circular lap
// buffer whose entries can be recalled oldest-first while paused.
module lap_stop_watch #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int LAP_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_p,
    input  logic [2:0]                       btn_pedge,
    output logic [23:0]                      value,
    output logic                             running,
    output logic                             show_lap,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic [$clog2(LAP_DEPTH)-1:0]     lap_idx,
    output logic                             overflow
);
    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = $clog2(DIV);
    localparam int CW  = $clog2(LAP_DEPTH + 1);
    localparam int IW  = $clog2(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [23:0]     time_reg, time_next;
    logic [IW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [IW-1:0]   lap_idx_reg, lap_idx_next;
    logic [IW-1:0]   rd_addr;
    logic [CW-1:0]   lap_count_reg, lap_count_next;
    logic            show_reg, show_next;
    logic            ovf_reg, ovf_next;
    logic            running_reg;
    logic [23:0]     value_reg;
    logic [23:0]     lap_mem [LAP_DEPTH];

    logic            clear_act, ss_act, lap_act, tick, lap_wr, recall;
    logic [23:0]     time_inc;
    logic            time_wrap;
    logic [6:0]      carry;

    // Clear only counts when it actually acts (PAUSE); it then masks the others.
    assign clear_act = btn_pedge[2] && (state_reg == PAUSE);
    assign ss_act    = btn_pedge[0] && !clear_act;
    assign lap_act   = btn_pedge[1] && !btn_pedge[0] && !clear_act;
    assign tick      = (state_reg == RUN) && (presc_reg == PW'(DIV - 1));
    assign lap_wr    = lap_act && (state_reg == RUN);
    assign recall    = lap_act && (state_reg == PAUSE) && (lap_count_reg != '0);

    // Ripple BCD increment; tens-of-seconds and tens-of-minutes wrap at 5.
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 3 || gi == 5) ? 4'd5 : 4'd9;
            logic [3:0] d;
            assign d = time_reg[4*gi +: 4];
            assign time_inc[4*gi +: 4] = !carry[gi] ? d : ((d == LIM) ? 4'd0 : d + 4'd1);
            assign carry[gi+1] = carry[gi] && (d == LIM);
        end
    endgenerate
    assign time_wrap = carry[6];

    always_ff @(posedge clk) begin
        if (reset_p) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clear_act) begin
            state_next = IDLE;
        end else if (ss_act) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        presc_next     = presc_reg;
        time_next      = time_reg;
        ovf_next       = ovf_reg;
        wr_ptr_next    = wr_ptr_reg;
        lap_count_next = lap_count_reg;
        show_next      = show_reg;
        lap_idx_next   = lap_idx_reg;

        if (state_reg == RUN) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
                time_next = time_inc;
                if (time_wrap) ovf_next = 1'b1;
            end
        end
        if (lap_wr) begin
            wr_ptr_next = wr_ptr_reg + IW'(1);
            if (lap_count_reg < CW'(LAP_DEPTH)) lap_count_next = lap_count_reg + CW'(1);
        end
        if (recall) begin
            if (!show_reg) begin
                show_next    = 1'b1;
                lap_idx_next = '0;
            end else if (CW'(lap_idx_reg) + CW'(1) < lap_count_reg) begin
                lap_idx_next = lap_idx_reg + IW'(1);
            end else begin
                show_next    = 1'b0;
                lap_idx_next = '0;
            end
        end
        if (ss_act) begin
            show_next    = 1'b0;
            lap_idx_next = '0;
        end
        if (clear_act) begin
            presc_next     = '0;
            time_next      = '0;
            ovf_next       = 1'b0;
            wr_ptr_next    = '0;
            lap_count_next = '0;
            show_next      = 1'b0;
            lap_idx_next   = '0;
        end
        // Truncating lap_count is the mod-LAP_DEPTH step since depth is a power of 2.
        rd_addr = wr_ptr_next - lap_count_next[IW-1:0] + lap_idx_next;
    end

    always_ff @(posedge clk) begin
        if (lap_wr) lap_mem[wr_ptr_reg] <= time_reg;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            presc_reg     <= '0;
            time_reg      <= '0;
            ovf_reg       <= 1'b0;
            wr_ptr_reg    <= '0;
            lap_count_reg <= '0;
            show_reg      <= 1'b0;
            lap_idx_reg   <= '0;
            running_reg   <= 1'b0;
            value_reg     <= '0;
        end else begin
            presc_reg     <= presc_next;
            time_reg      <= time_next;
            ovf_reg       <= ovf_next;
            wr_ptr_reg    <= wr_ptr_next;
            lap_count_reg <= lap_count_next;
            show_reg      <= show_next;
            lap_idx_reg   <= lap_idx_next;
            running_reg   <= (state_next == RUN);
            value_reg     <= show_next ? lap_mem[rd_addr] : time_next;
        end
    end

    assign value     = value_reg;
    assign running   = running_reg;
    assign show_lap  = show_reg;
    assign lap_count = lap_count_reg;
    assign lap_idx   = lap_idx_reg;
    assign overflow  = ovf_reg;
endmodule

// File: tb/tb_lap_stop_watch.sv
// Bench for lap_stop_watch: a centisecond/queue model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_lap_stop_watch;
    localparam int CLK_HZ    = 1000;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / 100;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [2:0]  btn_pedge = 3'b000;
    logic [23:0] value;
    logic        running, show_lap, overflow;
    logic [2:0]  lap_count;
    logic [1:0]  lap_idx;

    always #5 clk = ~clk;

    lap_stop_watch #(.CLK_HZ(CLK_HZ), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk(clk), .reset_p(reset_p), .btn_pedge(btn_pedge), .value(value),
        .running(running), .show_lap(show_lap), .lap_count(lap_count),
        .lap_idx(lap_idx), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Model: 0=idle 1=run 2=pause; time kept as total centiseconds.
    int m_state = 0, m_frac = 0, m_cs = 0, m_ovf = 0, m_show = 0, m_idx = 0;
    int m_laps[$];

    function automatic logic [23:0] to_bcd(input int cs);
        int mins, secs, c;
        mins = cs / 6000;
        secs = (cs / 100) % 60;
        c    = cs % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] exp_value();
        if (m_show != 0) return to_bcd(m_laps[m_idx]);
        return to_bcd(m_cs);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [2:0] b, input logic r);
        bit clr, ss, lp;
        if (r) begin
            m_state = 0; m_frac = 0; m_cs = 0; m_ovf = 0; m_show = 0; m_idx = 0;
            m_laps.delete();
            return;
        end
        clr = b[2] && (m_state == 2);
        ss  = b[0] && !clr;
        lp  = b[1] && !b[0] && !clr;
        if (m_state == 1) begin
            if (lp) begin
                m_laps.push_back(m_cs);
                if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_front());
            end
            if (m_frac == DIV - 1) begin
                m_frac = 0;
                if (m_cs == 359999) begin m_cs = 0; m_ovf = 1; end
                else m_cs++;
            end else begin
                m_frac++;
            end
        end else if (m_state == 2 && lp && m_laps.size() > 0) begin
            if (m_show == 0) begin m_show = 1; m_idx = 0; end
            else if (m_idx < m_laps.size() - 1) m_idx++;
            else begin m_show = 0; m_idx = 0; end
        end
        if (ss) begin
            m_show = 0; m_idx = 0;
            m_state = (m_state == 1) ? 2 : 1;
        end
        if (clr) begin
            m_state = 0; m_frac = 0; m_cs = 0; m_ovf = 0; m_show = 0; m_idx = 0;
            m_laps.delete();
        end
    endtask

    task automatic step(input logic [2:0] b, input logic r = 1'b0);
        btn_pedge = b;
        reset_p   = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        btn_pedge = 3'b000;
        reset_p   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("value",     32'(value),     32'(exp_value()));
            chk("running",   32'(running),   32'(m_state == 1));
            chk("show_lap",  32'(show_lap),  32'(m_show));
            chk("lap_count", 32'(lap_count), 32'(m_laps.size()));
            chk("lap_idx",   32'(lap_idx),   32'(m_idx));
            chk("overflow",  32'(overflow),  32'(m_ovf));
        end
    end

    logic [23:0] exp_laps [4];

    initial begin
        exp_laps = '{24'h000020, 24'h000030, 24'h000040, 24'h000050};

        step(3'b000, 1'b1);
        check_en = 1'b1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_lap_count", 32'(lap_count), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);

        // 1000 run clocks = 100 ticks = 1.00 s, then freeze.
        step(3'b001);
        idle(1000);
        chk("run_1s_value", 32'(value), 32'h000100);
        chk("run_1s_running", 32'(running), 32'h1);
        step(3'b001);
        chk("pause_running", 32'(running), 32'h0);
        idle(500);
        chk("pause_frozen", 32'(value), 32'h000100);

        // Five laps at 0.10..0.50 s into a 4-deep buffer; recall oldest first.
        step(3'b000, 1'b1);
        step(3'b001);
        idle(100);
        step(3'b010);
        repeat (4) begin
            idle(99);
            step(3'b010);
        end
        chk("lap_count_sat", 32'(lap_count), 32'h4);
        step(3'b001);
        for (int k = 0; k < 4; k++) begin
            step(3'b010);
            chk("recall_value", 32'(value), 32'(exp_laps[k]));
            chk("recall_show", 32'(show_lap), 32'h1);
            chk("recall_idx", 32'(lap_idx), 32'(k));
        end
        step(3'b010);
        chk("recall_end_show", 32'(show_lap), 32'h0);
        chk("recall_end_value", 32'(value), 32'h000050);

        // start/stop beats lap; clear beats start/stop.
        step(3'b000, 1'b1);
        step(3'b001);
        idle(50);
        step(3'b011);
        chk("ss_lap_running", 32'(running), 32'h0);
        chk("ss_lap_count", 32'(lap_count), 32'h0);
        step(3'b101);
        chk("clr_ss_running", 32'(running), 32'h0);
        chk("clr_ss_value", 32'(value), 32'h0);
        step(3'b001);
        chk("idle_start_running", 32'(running), 32'h1);
        chk("idle_start_value", 32'(value), 32'h0);

        // Clear is ignored in RUN, acts in PAUSE.
        idle(30);
        step(3'b100);
        chk("clr_run_running", 32'(running), 32'h1);
        idle(20);
        chk("clr_run_value", 32'(value), 32'h000005);
        step(3'b010);
        step(3'b001);
        chk("clr_pre_count", 32'(lap_count), 32'h1);
        step(3'b100);
        chk("clr_value", 32'(value), 32'h0);
        chk("clr_count", 32'(lap_count), 32'h0);
        chk("clr_running", 32'(running), 32'h0);

        // Overflow: preload 59:59.99 while paused with fraction 4.
        step(3'b001);
        idle(3);
        step(3'b001);
        check_en = 1'b0;
        force dut.time_reg = 24'h595999;
        m_cs = 359999;
        step(3'b000);
        release dut.time_reg;
        check_en = 1'b1;
        chk("preload_value", 32'(value), 32'h595999);
        step(3'b001);
        idle(5);
        chk("pre_wrap_value", 32'(value), 32'h595999);
        chk("pre_wrap_ovf", 32'(overflow), 32'h0);
        step(3'b000);
        chk("wrap_value", 32'(value), 32'h000000);
        chk("wrap_ovf", 32'(overflow), 32'h1);
        chk("wrap_running", 32'(running), 32'h1);
        idle(200);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        step(3'b001);
        step(3'b100);
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Reset during recall with three laps.
        step(3'b000, 1'b1);
        step(3'b001);
        repeat (3) begin
            idle(10);
            step(3'b010);
        end
        step(3'b001);
        step(3'b010);
        chk("mid_recall_show", 32'(show_lap), 32'h1);
        chk("mid_recall_count", 32'(lap_count), 32'h3);
        step(3'b010);
        step(3'b000, 1'b1);
        chk("rst2_value", 32'(value), 32'h0);
        chk("rst2_show", 32'(show_lap), 32'h0);
        chk("rst2_count", 32'(lap_count), 32'h0);
        chk("rst2_idx", 32'(lap_idx), 32'h0);
        chk("rst2_running", 32'(running), 32'h0);
        step(3'b001);
        idle(7);
        step(3'b001);
        step(3'b010);
        chk("post_rst_recall_show", 32'(show_lap), 32'h0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
